// File: rtl/arbitro_escrita.sv
// Round-robin arbiter sharing the register bank write port among NREQ requesters.
// A winner that asks for it may keep the port for a burst of up to MAX_RAJADA writes.
module arbitro_escrita #(
    parameter int NREQ       = 4,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int MAX_RAJADA = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_rajada,
    input  logic [NREQ*ADDR_W-1:0]   req_end,
    input  logic [NREQ*DATA_W-1:0]   req_dado,
    output logic [NREQ-1:0]          req_pronto,
    output logic [ADDR_W-1:0]        regE,
    output logic [DATA_W-1:0]        EscData,
    output logic                     escrita,
    output logic [2:0]               grant_id,
    output logic                     ocupado
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 5;

    typedef enum logic {
        LIVRE,
        RAJADA
    } estado_t;

    estado_t            r_estado, w_estado_prox;
    logic [IDX_W-1:0]   r_ptr, w_ptr_prox;
    logic [IDX_W-1:0]   r_dono, w_dono_prox;
    logic [CNT_W-1:0]   r_cnt, w_cnt_prox;
    logic [IDX_W-1:0]   w_idx;
    logic               w_achou;
    logic [ADDR_W-1:0]  w_end;
    logic [DATA_W-1:0]  w_dado;

    function automatic logic [IDX_W-1:0] proximo(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NREQ - 1) return '0;
        else                       return idx + 1'b1;
    endfunction

    // Winner selection: locked owner in RAJADA, otherwise first valid from ptr upward.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        int cand;
        cand       = 0;
        w_idx      = r_ptr;
        w_achou    = 1'b0;
        req_pronto = '0;
        if (r_estado == RAJADA) begin
            w_idx   = r_dono;
            w_achou = req_valid[r_dono];
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = (int'(r_ptr) + k) % NREQ;
                if (!w_achou && req_valid[cand]) begin
                    w_achou = 1'b1;
                    w_idx   = IDX_W'(cand);
                end
            end
        end
        if (w_achou) req_pronto[w_idx] = 1'b1;
    end

    // Data mux keyed by the one-hot ready, so no path from data to ready exists.
    always_comb begin
        w_end  = '0;
        w_dado = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_end  = w_end  | (req_end[i*ADDR_W +: ADDR_W] & {ADDR_W{req_pronto[i]}});
            w_dado = w_dado | (req_dado[i*DATA_W +: DATA_W] & {DATA_W{req_pronto[i]}});
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        w_ptr_prox    = r_ptr;
        w_dono_prox   = r_dono;
        w_cnt_prox    = r_cnt;
        if (r_estado == LIVRE) begin
            if (w_achou) begin
                if (req_rajada[w_idx] && (MAX_RAJADA > 1)) begin
                    w_estado_prox = RAJADA;
                    w_dono_prox   = w_idx;
                    w_cnt_prox    = CNT_W'(1);
                end else begin
                    w_ptr_prox = proximo(w_idx);
                end
            end
        end else begin
            // Owner idle, owner done, or burst cap reached: release the port.
            if (!w_achou || !req_rajada[r_dono] || (int'(r_cnt) + 1 == MAX_RAJADA)) begin
                w_estado_prox = LIVRE;
                w_ptr_prox    = proximo(r_dono);
                w_cnt_prox    = '0;
            end else begin
                w_cnt_prox = r_cnt + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= LIVRE;
            r_ptr    <= '0;
            r_dono   <= '0;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_estado_prox;
            r_ptr    <= w_ptr_prox;
            r_dono   <= w_dono_prox;
            r_cnt    <= w_cnt_prox;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regE     <= '0;
            EscData  <= '0;
            escrita  <= 1'b0;
            grant_id <= '0;
        end else begin
            escrita <= w_achou;
            if (w_achou) begin
                regE     <= w_end;
                EscData  <= w_dado;
                grant_id <= 3'(w_idx);
            end
        end
    end

    assign ocupado = (r_estado == RAJADA);

endmodule

// File: tb/tb_arbitro_escrita.sv
// Directed bench for arbitro_escrita: table of round-robin/burst vectors plus
// hand-written sequences for idle hold, early burst end and mid-burst reset.
module tb_arbitro_escrita;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_rajada;
    logic [11:0] req_end;
    logic [31:0] req_dado;
    logic [3:0]  req_pronto;
    logic [2:0]  regE;
    logic [7:0]  EscData;
    logic        escrita;
    logic [2:0]  grant_id;
    logic        ocupado;

    int n_checks = 0;
    int n_fail   = 0;

    arbitro_escrita #(
        .NREQ(4), .DATA_W(8), .ADDR_W(3), .MAX_RAJADA(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rajada (req_rajada),
        .req_end    (req_end),
        .req_dado   (req_dado),
        .req_pronto (req_pronto),
        .regE       (regE),
        .EscData    (EscData),
        .escrita    (escrita),
        .grant_id   (grant_id),
        .ocupado    (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] rajada;
        logic [3:0] pronto;
        logic       esc;
        logic [2:0] reg_e;
        logic [7:0] dado;
        logic [2:0] grant;
        logic       ocup;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] pronto, input logic esc,
                            input logic [2:0] reg_e, input logic [7:0] dado,
                            input logic [2:0] grant, input logic ocup);
        check({tag, ".pronto"},   32'(req_pronto), 32'(pronto));
        check({tag, ".escrita"},  32'(escrita),    32'(esc));
        check({tag, ".regE"},     32'(regE),       32'(reg_e));
        check({tag, ".EscData"},  32'(EscData),    32'(dado));
        check({tag, ".grant_id"}, 32'(grant_id),   32'(grant));
        check({tag, ".ocupado"},  32'(ocupado),    32'(ocup));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Registered outputs in row n show the transfer made at the end of row n-1.
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 3'd0, 8'h10, 3'd0, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 3'd1, 8'h11, 3'd1, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 3'd2, 8'h12, 3'd2, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 3'd3, 8'h13, 3'd3, 1'b0};
        vecs[5]  = '{4'b0110, 4'b0010, 4'b0010, 1'b1, 3'd0, 8'h10, 3'd0, 1'b0};
        vecs[6]  = '{4'b0110, 4'b0010, 4'b0010, 1'b1, 3'd1, 8'h11, 3'd1, 1'b1};
        vecs[7]  = '{4'b0110, 4'b0010, 4'b0010, 1'b1, 3'd1, 8'h11, 3'd1, 1'b1};
        vecs[8]  = '{4'b0110, 4'b0010, 4'b0010, 1'b1, 3'd1, 8'h11, 3'd1, 1'b1};
        vecs[9]  = '{4'b0110, 4'b0010, 4'b0100, 1'b1, 3'd1, 8'h11, 3'd1, 1'b0};
        vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 3'd2, 8'h12, 3'd2, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd2, 8'h12, 3'd2, 1'b0};

        reset      = 1'b0;
        req_valid  = 4'b1111;
        req_rajada = 4'b0000;
        req_end    = 12'h688;
        req_dado   = 32'h13121110;

        repeat (2) @(posedge clock);
        #1;
        chk_outs("reset", 4'b0001, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            req_valid  = vecs[i].valid;
            req_rajada = vecs[i].rajada;
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].pronto, vecs[i].esc, vecs[i].reg_e,
                     vecs[i].dado, vecs[i].grant, vecs[i].ocup);
            tick();
        end

        // Idle hold: write 0x43 to reg 5 from req2, then five idle cycles.
        req_end[6 +: 3]  = 3'd5;
        req_dado[16 +: 8] = 8'h43;
        req_valid  = 4'b0100;
        req_rajada = 4'b0000;
        #1;
        chk_outs("idle0", 4'b0100, 1'b0, 3'd2, 8'h12, 3'd2, 1'b0);
        tick();
        req_valid = 4'b0000;
        #1;
        chk_outs("idle_w", 4'b0000, 1'b1, 3'd5, 8'h43, 3'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk_outs($sformatf("idle%0d", i + 1), 4'b0000, 1'b0, 3'd5, 8'h43, 3'd2, 1'b0);
        end
        req_end  = 12'h688;
        req_dado = 32'h13121110;

        // Early burst end: req0 bursts twice, then drops valid; req1 follows.
        req_valid  = 4'b0011;
        req_rajada = 4'b0001;
        #1;
        chk_outs("eb0", 4'b0001, 1'b0, 3'd5, 8'h43, 3'd2, 1'b0);
        tick();
        #1;
        chk_outs("eb1", 4'b0001, 1'b1, 3'd0, 8'h10, 3'd0, 1'b1);
        tick();
        req_valid = 4'b0010;
        #1;
        chk_outs("eb2", 4'b0000, 1'b1, 3'd0, 8'h10, 3'd0, 1'b1);
        tick();
        #1;
        chk_outs("eb3", 4'b0010, 1'b0, 3'd0, 8'h10, 3'd0, 1'b0);
        tick();
        #1;
        chk_outs("eb4", 4'b0010, 1'b1, 3'd1, 8'h11, 3'd1, 1'b0);

        // Mid-burst reset: req3 bursts, reset between edges, req0 granted first after.
        req_valid  = 4'b1001;
        req_rajada = 4'b1000;
        #1;
        chk_outs("mr0", 4'b1000, 1'b1, 3'd1, 8'h11, 3'd1, 1'b0);
        tick();
        #1;
        chk_outs("mr1", 4'b1000, 1'b1, 3'd3, 8'h13, 3'd3, 1'b1);
        tick();
        #1;
        chk_outs("mr2", 4'b1000, 1'b1, 3'd3, 8'h13, 3'd3, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_outs("mr_rst", 4'b0001, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0);
        #1;
        reset = 1'b1;
        tick();
        #1;
        chk_outs("mr3", 4'b1000, 1'b1, 3'd0, 8'h10, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
